lockstep_checker: RTL
=====================

LOCKSTEP_CHECKER -- requirements
Module: lockstep_checker

Interface
REQ-001 SHALL have parameter RECOVERY_CYCLES, default 4: cycles the cores are held in reset after a detected error (legal range 1..255).
REQ-002 SHALL have parameter COUNT_W, default 16: width of the detected-error counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port fetch_enable_i, input, 1 bit: SoC-level run request.
REQ-006 SHALL have ports core0_instr_addr_i and core1_instr_addr_i, input, 32 bits each: fetch address of each core.
REQ-007 SHALL have ports core0_data_req_i and core1_data_req_i, input, 1 bit each: data request of each core.
REQ-008 SHALL have ports core0_data_we_i and core1_data_we_i, input, 1 bit each: write enable of each core.
REQ-009 SHALL have ports core0_data_addr_i and core1_data_addr_i, input, 32 bits each: data address of each core.
REQ-010 SHALL have ports core0_data_wdata_i and core1_data_wdata_i, input, 32 bits each: write data of each core.
REQ-011 SHALL have port core_fetch_enable_o, output, 1 bit: fetch enable to both cores.
REQ-012 SHALL have port core_rst_no, output, 1 bit: active-low reset to both cores.
REQ-013 SHALL have port data_block_o, output, 1 bit: when high, the memory side drops this cycle's data request.
REQ-014 SHALL have port error_o, output, 1 bit: one-cycle pulse per detected divergence.
REQ-015 SHALL have port recovering_o, output, 1 bit: high while in ERROR, RECOVER or RESTART.
REQ-016 SHALL have port error_count_o, output, COUNT_W bits: number of detected divergences.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN, ERROR, RECOVER, RESTART.
REQ-018 In IDLE, fetch_enable_i=1 SHALL move to RUN on the next edge; otherwise the FSM stays in IDLE.
REQ-019 mismatch SHALL be a combinational signal that is 1 when any of the following holds:
- instr_addr differs between the cores;
- data_req differs;
- both data_req are high and data_we differs;
- both data_req are high and data_addr differs;
- both data_req and both data_we are high and data_wdata differs.
REQ-020 In RUN, mismatch=1 SHALL move to ERROR, taking priority over fetch_enable_i=0.
REQ-021 In RUN, mismatch=0 with fetch_enable_i=0 SHALL move to IDLE.
REQ-022 ERROR SHALL last exactly one cycle, then move to RECOVER.
REQ-023 RECOVER SHALL last exactly RECOVERY_CYCLES cycles, counted by a down-counter, then move to RESTART.
REQ-024 RESTART SHALL last one cycle, then move to RUN if fetch_enable_i=1, else to IDLE.
REQ-025 mismatch and fetch_enable_i SHALL be ignored in ERROR and RECOVER.
REQ-026 error_o SHALL be 1 exactly in the ERROR state, i.e. registered: the cycle after the mismatch is seen.
REQ-027 error_count_o SHALL increment by one on entry to ERROR and saturate at 2^COUNT_W-1; it is cleared only by reset.
REQ-028 core_rst_no SHALL be 0 in ERROR and RECOVER and 1 in all other states.
REQ-029 core_fetch_enable_o SHALL be 1 only in RUN.
REQ-030 data_block_o SHALL be combinational: 1 when state!=RUN, or when state==RUN and mismatch=1, so that a divergent write never commits.
REQ-031 Equal but garbage data_addr/data_wdata with both data_req low SHALL NOT flag a mismatch.

Reset
REQ-032 On rst_ni=0 the block SHALL asynchronously set:
- state to IDLE;
- the recovery counter and error_count_o to 0;
- error_o=0, core_fetch_enable_o=0, core_rst_no=0, recovering_o=0.
data_block_o is then 1.
REQ-033 rst_ni asserted mid-recovery SHALL abort recovery with no further error_o pulse.

Structure
REQ-034 Package lockstep_pkg SHALL hold the state enum and a packed struct core_bus_t (instr_addr, data_req, data_we, data_addr, data_wdata).
REQ-035 The comparison SHALL live in a combinational sub-module lockstep_compare (two core_bus_t in, mismatch out); the FSM and counters stay in lockstep_checker.

Verification
REQ-036 Reset, then fetch_enable_i=1 with identical buses -> RUN after 1 cycle; core_fetch_enable_o=1; error_o never pulses over 1000 cycles.
REQ-037 In RUN, core1_data_wdata_i=0x5 vs core0=0x4, both req=1, we=1 -> same cycle data_block_o=1; next cycle error_o=1 and error_count_o=1; core_rst_no=0 for 1+4 cycles; RESTART; back in RUN.
REQ-038 Both req=0 with data_addr 0x10 vs 0x20 -> no mismatch and no error.
REQ-039 Mismatch in the same cycle as fetch_enable_i=0 -> ERROR taken; after RESTART, FSM goes to IDLE.
REQ-040 COUNT_W=2 with 5 injected divergences -> error_count_o reads 1,2,3,3,3.
REQ-041 rst_ni=0 during the second RECOVER cycle -> all outputs immediately at reset values; error_count_o=0.

Source files
------------

// File: rtl/lockstep_pkg.sv
// Shared types for the dual-core lockstep checker: FSM state encoding and the
// per-core bus snapshot that is compared every cycle.
package lockstep_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        ERROR   = 3'd2,
        RECOVER = 3'd3,
        RESTART = 3'd4
    } state_e;

    typedef struct packed {
        logic [31:0] instr_addr;
        logic        data_req;
        logic        data_we;
        logic [31:0] data_addr;
        logic [31:0] data_wdata;
    } core_bus_t;

endpackage

// File: rtl/lockstep_compare.sv
// Combinational divergence detector between two core buses. Data fields only
// count when the qualifying request/write strobes are asserted on both cores.
module lockstep_compare
    import lockstep_pkg::*;
(
    input  core_bus_t bus0,
    input  core_bus_t bus1,
    output logic      mismatch
);

    logic both_req;
    logic both_we;

    assign both_req = bus0.data_req & bus1.data_req;
    assign both_we  = bus0.data_we & bus1.data_we;

    assign mismatch = (bus0.instr_addr != bus1.instr_addr)
                    | (bus0.data_req != bus1.data_req)
                    | (both_req & (bus0.data_we != bus1.data_we))
                    | (both_req & (bus0.data_addr != bus1.data_addr))
                    | (both_req & both_we & (bus0.data_wdata != bus1.data_wdata));

endmodule

// File: rtl/lockstep_checker.sv
// Lockstep supervisor for two redundant cores: compares their buses, blocks
// divergent memory traffic, and resets both cores for a fixed recovery window.
module lockstep_checker
    import lockstep_pkg::*;
#(
    parameter int unsigned RECOVERY_CYCLES = 4,
    parameter int unsigned COUNT_W         = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               fetch_enable_i,
    input  logic [31:0]        core0_instr_addr_i,
    input  logic [31:0]        core1_instr_addr_i,
    input  logic               core0_data_req_i,
    input  logic               core1_data_req_i,
    input  logic               core0_data_we_i,
    input  logic               core1_data_we_i,
    input  logic [31:0]        core0_data_addr_i,
    input  logic [31:0]        core1_data_addr_i,
    input  logic [31:0]        core0_data_wdata_i,
    input  logic [31:0]        core1_data_wdata_i,
    output logic               core_fetch_enable_o,
    output logic               core_rst_no,
    output logic               data_block_o,
    output logic               error_o,
    output logic               recovering_o,
    output logic [COUNT_W-1:0] error_count_o
);

    localparam logic [7:0]         RECOVER_LOAD = 8'(RECOVERY_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;

    core_bus_t          bus0, bus1;
    logic               mismatch;
    state_e             state_q, state_d;
    logic [7:0]         rec_cnt_q, rec_cnt_d;
    logic [COUNT_W-1:0] err_cnt_q;
    logic               error_q, fetch_en_q, core_rst_q, recovering_q;

    assign bus0 = '{instr_addr: core0_instr_addr_i, data_req: core0_data_req_i,
                    data_we: core0_data_we_i, data_addr: core0_data_addr_i,
                    data_wdata: core0_data_wdata_i};
    assign bus1 = '{instr_addr: core1_instr_addr_i, data_req: core1_data_req_i,
                    data_we: core1_data_we_i, data_addr: core1_data_addr_i,
                    data_wdata: core1_data_wdata_i};

    lockstep_compare u_compare (
        .bus0     (bus0),
        .bus1     (bus1),
        .mismatch (mismatch)
    );

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        case (state_q)
            IDLE:    if (fetch_enable_i) state_d = RUN;
            RUN: begin
                if (mismatch)             state_d = ERROR;
                else if (!fetch_enable_i) state_d = IDLE;
            end
            ERROR: begin
                state_d   = RECOVER;
                rec_cnt_d = RECOVER_LOAD;
            end
            RECOVER: begin
                if (rec_cnt_q == 8'd0) state_d = RESTART;
                else                   rec_cnt_d = rec_cnt_q - 8'd1;
            end
            RESTART: state_d = fetch_enable_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q
    // while core_rst_no can still come out of reset low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            error_q      <= 1'b0;
            fetch_en_q   <= 1'b0;
            core_rst_q   <= 1'b0;
            recovering_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rec_cnt_q    <= rec_cnt_d;
            if (state_q == RUN && mismatch && err_cnt_q != COUNT_MAX)
                err_cnt_q <= err_cnt_q + COUNT_W'(1);
            error_q      <= (state_d == ERROR);
            fetch_en_q   <= (state_d == RUN);
            core_rst_q   <= !(state_d == ERROR || state_d == RECOVER);
            recovering_q <= (state_d == ERROR || state_d == RECOVER || state_d == RESTART);
        end
    end

    assign data_block_o        = (state_q != RUN) | mismatch;
    assign error_o             = error_q;
    assign core_fetch_enable_o = fetch_en_q;
    assign core_rst_no         = core_rst_q;
    assign recovering_o        = recovering_q;
    assign error_count_o       = err_cnt_q;

endmodule
